// File: rtl/level_ctrl_pkg.sv
// Shared definitions for the level step controller: level-mode encodings,
// the per-button repeat FSM state type and a counter-width helper.
package level_ctrl_pkg;

  // Behaviour at the ends of the level range.
  localparam int unsigned MODE_SATURATE = 0;
  localparam int unsigned MODE_WRAP     = 1;

  // Hold-to-repeat state per button.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HELD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/level_debounce.sv
// One push-button input path: 2-FF synchroniser followed by a stable-count
// debouncer. o_sw follows the synchronised input only after it has differed
// from o_sw for DEBOUNCE_CNT consecutive cycles; any bounce restarts the
// count. o_rise pulses for one cycle together with a 0->1 change of o_sw.
module level_debounce
  import level_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 250000
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sw_q, sw_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser shift and stable counter; counter stops at its terminal
  // count because the debounced value takes over and the difference ends.
  always_comb begin
    sync1_d = i_sw;
    sync2_d = sync1_q;
    sw_d    = sw_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != sw_q) begin
      if (cnt_q >= CNT_LAST) begin
        sw_d   = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // All state clears to the released value on reset.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sw_q    <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sw   = sw_q;
  assign o_rise = rise_q;

endmodule

// File: rtl/level_ctrl.sv
// N-level step controller: two debounced buttons step a level register up or
// down, with saturate or wrap at the ends, registered min/max flags and a
// one-cycle change strobe. Defining AUTOREPEAT_EN adds hold-to-repeat: after
// HOLD_CNT cycles held a button steps again, then every REPEAT_CNT cycles.
module level_ctrl
  import level_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LEVELS   = 4,
  parameter int unsigned LEVEL_W      = 2,
  parameter int unsigned RESET_LEVEL  = 0,
  parameter int unsigned DEBOUNCE_CNT = 250000,
  parameter int unsigned WRAP         = 0,
  parameter int unsigned HOLD_CNT     = 25000000,
  parameter int unsigned REPEAT_CNT   = 6250000
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_up,
  input  logic               i_down,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_changed,
  output logic               o_at_min,
  output logic               o_at_max
);

  localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LEVEL_W-1:0] RST_LVL = LEVEL_W'(RESET_LEVEL);

  // Index 0 = up button, index 1 = down button.
  logic [1:0] btn_sw;
  logic [1:0] btn_rise;
  logic [1:0] step;

  level_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_up (
    .clk    (clk),
    .i_reset(i_reset),
    .i_sw   (i_up),
    .o_sw   (btn_sw[0]),
    .o_rise (btn_rise[0])
  );

  level_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_dn (
    .clk    (clk),
    .i_reset(i_reset),
    .i_sw   (i_down),
    .o_sw   (btn_sw[1]),
    .o_rise (btn_rise[1])
  );

`ifdef AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CNT - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CNT - 1);

  rpt_state_e       st_q   [2];
  rpt_state_e       st_d   [2];
  logic [RPT_W-1:0] rcnt_q [2];
  logic [RPT_W-1:0] rcnt_d [2];

  // Repeat FSM state register, one per button.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]   <= RPT_IDLE;
        rcnt_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]   <= st_d[b];
        rcnt_q[b] <= rcnt_d[b];
      end
    end
  end

  // Next state: a debounced release returns to IDLE from anywhere.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b]   = st_q[b];
      rcnt_d[b] = rcnt_q[b];
      case (st_q[b])
        RPT_IDLE: begin
          rcnt_d[b] = '0;
          if (btn_rise[b]) st_d[b] = RPT_HELD;
        end
        RPT_HELD: begin
          if (!btn_sw[b]) begin
            st_d[b]   = RPT_IDLE;
            rcnt_d[b] = '0;
          end else if (rcnt_q[b] >= HOLD_LAST) begin
            st_d[b]   = RPT_REPEAT;
            rcnt_d[b] = '0;
          end else begin
            rcnt_d[b] = rcnt_q[b] + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (!btn_sw[b]) begin
            st_d[b]   = RPT_IDLE;
            rcnt_d[b] = '0;
          end else if (rcnt_q[b] >= RPT_LAST) begin
            rcnt_d[b] = '0;
          end else begin
            rcnt_d[b] = rcnt_q[b] + 1'b1;
          end
        end
        default: begin
          st_d[b]   = RPT_IDLE;
          rcnt_d[b] = '0;
        end
      endcase
    end
  end

  // Step outputs: on press, at end of hold, and at each repeat interval.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      step[b] = 1'b0;
      case (st_q[b])
        RPT_IDLE:   step[b] = btn_rise[b];
        RPT_HELD:   step[b] = btn_sw[b] && (rcnt_q[b] >= HOLD_LAST);
        RPT_REPEAT: step[b] = btn_sw[b] && (rcnt_q[b] >= RPT_LAST);
        default:    step[b] = 1'b0;
      endcase
    end
  end
`else
  // One step per debounced press; the held level and repeat timing are not used.
  assign step = btn_rise;

  logic unused_cfg;
  assign unused_cfg = ^{btn_sw, 32'(HOLD_CNT), 32'(REPEAT_CNT)};
`endif

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               changed_q, changed_d;
  logic               at_min_q, at_min_d;
  logic               at_max_q, at_max_d;
  logic               up_ev, dn_ev;

  // Step arithmetic; coincident up and down steps cancel.
  always_comb begin
    up_ev   = step[0] & ~step[1];
    dn_ev   = step[1] & ~step[0];
    level_d = level_q;
    if (up_ev) begin
      if (level_q >= MAX_LVL) level_d = (WRAP == MODE_WRAP) ? '0 : MAX_LVL;
      else                    level_d = level_q + 1'b1;
    end else if (dn_ev) begin
      if (level_q == '0) level_d = (WRAP == MODE_WRAP) ? MAX_LVL : '0;
      else               level_d = level_q - 1'b1;
    end
    changed_d = (level_d != level_q);
    at_min_d  = (level_d == '0);
    at_max_d  = (level_d == MAX_LVL);
  end

  // Level, strobe and flags are registered together so they always agree.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      level_q   <= RST_LVL;
      changed_q <= 1'b0;
      at_min_q  <= (RST_LVL == '0);
      at_max_q  <= (RST_LVL == MAX_LVL);
    end else begin
      level_q   <= level_d;
      changed_q <= changed_d;
      at_min_q  <= at_min_d;
      at_max_q  <= at_max_d;
    end
  end

  assign o_level   = level_q;
  assign o_changed = changed_q;
  assign o_at_min  = at_min_q;
  assign o_at_max  = at_max_q;

endmodule

// File: tb/tb_level_ctrl.sv
// Bench for level_ctrl. Four instances: 0 saturating, 1 wrapping,
// 2 RESET_LEVEL=3, 3 eight levels for the hold test. All use DEBOUNCE_CNT=4.
module tb_level_ctrl;

  localparam int DEB   = 4;
  localparam int LAT   = DEB + 3;
  localparam int HOLD  = 20;
  localparam int RPT   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [4];
  logic       up    [4];
  logic       dn    [4];
  logic [2:0] lvl   [4];
  logic       chg   [4];
  logic       amin  [4];
  logic       amax  [4];

  int chg_cnt [4] = '{0, 0, 0, 0};
  int n_cmp = 0;
  int n_bad = 0;

  level_ctrl #(.NUM_LEVELS(5), .LEVEL_W(3), .RESET_LEVEL(0), .DEBOUNCE_CNT(DEB),
               .WRAP(0), .HOLD_CNT(HOLD), .REPEAT_CNT(RPT)) u_sat (
    .clk(clk), .i_reset(rst_n[0]), .i_up(up[0]), .i_down(dn[0]),
    .o_level(lvl[0]), .o_changed(chg[0]), .o_at_min(amin[0]), .o_at_max(amax[0]));

  level_ctrl #(.NUM_LEVELS(5), .LEVEL_W(3), .RESET_LEVEL(0), .DEBOUNCE_CNT(DEB),
               .WRAP(1), .HOLD_CNT(HOLD), .REPEAT_CNT(RPT)) u_wrap (
    .clk(clk), .i_reset(rst_n[1]), .i_up(up[1]), .i_down(dn[1]),
    .o_level(lvl[1]), .o_changed(chg[1]), .o_at_min(amin[1]), .o_at_max(amax[1]));

  level_ctrl #(.NUM_LEVELS(5), .LEVEL_W(3), .RESET_LEVEL(3), .DEBOUNCE_CNT(DEB),
               .WRAP(0), .HOLD_CNT(HOLD), .REPEAT_CNT(RPT)) u_rst (
    .clk(clk), .i_reset(rst_n[2]), .i_up(up[2]), .i_down(dn[2]),
    .o_level(lvl[2]), .o_changed(chg[2]), .o_at_min(amin[2]), .o_at_max(amax[2]));

  level_ctrl #(.NUM_LEVELS(8), .LEVEL_W(3), .RESET_LEVEL(0), .DEBOUNCE_CNT(DEB),
               .WRAP(0), .HOLD_CNT(HOLD), .REPEAT_CNT(RPT)) u_hold (
    .clk(clk), .i_reset(rst_n[3]), .i_up(up[3]), .i_down(dn[3]),
    .o_level(lvl[3]), .o_changed(chg[3]), .o_at_min(amin[3]), .o_at_max(amax[3]));

  // Count change strobes away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (chg[k]) chg_cnt[k]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Hold raw inputs for 12 cycles then release for 12; report the cycle of
  // the first change strobe after the raw edge and the number of strobes.
  task automatic press(input int k, input bit u, input bit d,
                       output int lat, output int pulses);
    int c0;
    c0  = chg_cnt[k];
    lat = -1;
    @(posedge clk); #1;
    up[k] = u;
    dn[k] = d;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (chg[k] && lat < 0) lat = i;
    end
    up[k] = 1'b0;
    dn[k] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    pulses = chg_cnt[k] - c0;
  endtask

  // Level the hold-test instance should show after edge e (raw press at 0,
  // raw release after edge 60).
  function automatic int hold_model(input int e);
    int n;
    int rel_edge;
    rel_edge = 60 + DEB + 2;
    n = (e >= LAT) ? 1 : 0;
`ifdef AUTOREPEAT_EN
    for (int s = LAT + HOLD; s <= rel_edge; s += RPT) if (e >= s) n++;
`endif
    return n;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int inst;
    bit u;
    bit d;
    int exp_lvl;
    bit exp_chg;
    bit exp_min;
    bit exp_max;
  } vec_t;

  vec_t tbl [16];

  int lat, pulses, c0;
  int hist [0:80];

  initial begin
    tbl[0]  = '{0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1};

    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b0;
      up[k]    = 1'b0;
      dn[k]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_level[%0d]", k), lvl[k], (k == 2) ? 3 : 0);
      chk($sformatf("reset_changed[%0d]", k), chg[k], 0);
      chk($sformatf("reset_at_min[%0d]", k), amin[k], (k == 2) ? 0 : 1);
      chk($sformatf("reset_at_max[%0d]", k), amax[k], 0);
    end
    for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;
    repeat (3) @(posedge clk);

    // Table-driven presses.
    for (int v = 0; v < 16; v++) begin
      press(tbl[v].inst, tbl[v].u, tbl[v].d, lat, pulses);
      chk($sformatf("vec%0d_level", v), lvl[tbl[v].inst], tbl[v].exp_lvl);
      chk($sformatf("vec%0d_pulses", v), pulses, tbl[v].exp_chg ? 1 : 0);
      chk($sformatf("vec%0d_at_min", v), amin[tbl[v].inst], tbl[v].exp_min);
      chk($sformatf("vec%0d_at_max", v), amax[tbl[v].inst], tbl[v].exp_max);
      if (tbl[v].exp_chg) chk($sformatf("vec%0d_latency", v), lat, LAT);
    end

    // Bouncing input and a short glitch are ignored (instance 0 at level 1).
    c0 = chg_cnt[0];
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      up[0] = ~up[0];
      repeat (2) @(posedge clk);
      #1;
    end
    up[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("bounce_level", lvl[0], 1);
    up[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    up[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("glitch_level", lvl[0], 1);
    chk("glitch_pulses", chg_cnt[0] - c0, 0);

    // Reset mid-debounce aborts the press; the held button steps once after release.
    c0 = chg_cnt[2];
    @(posedge clk); #1;
    dn[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_level", lvl[2], 3);
    #2;
    rst_n[2] = 1'b0;
    #1;
    chk("abort_level", lvl[2], 3);
    chk("abort_changed", chg[2], 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (chg[2] && lat < 0) lat = i;
    end
    chk("held_reset_latency", lat, LAT);
    chk("held_reset_level", lvl[2], 2);
    chk("held_reset_pulses", chg_cnt[2] - c0, 1);
    dn[2] = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Hold up for 60 cycles from level 0 on the eight-level instance.
    c0 = chg_cnt[3];
    @(posedge clk); #1;
    up[3] = 1'b1;
    hist[0] = lvl[3];
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      hist[i] = lvl[3];
      if (i == 60) up[3] = 1'b0;
    end
    begin
      int pts [12];
      pts = '{6, 7, 26, 27, 34, 35, 43, 51, 59, 66, 67, 80};
      for (int j = 0; j < 12; j++)
        chk($sformatf("hold_level_at_%0d", pts[j]), hist[pts[j]], hold_model(pts[j]));
    end
    chk("hold_pulses", chg_cnt[3] - c0, hold_model(80));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
